seq_check_consumer: RTL and testbench

// - Downstream sink for the 8-bit valid/rdy counting stream. Throttles the upstream producer with
//   a programmable backpressure pattern and checks that accepted words form a +1 sequence.
// - Reports transfer/error statistics; standalone endpoint of the valid/rdy demo chain.

---
 rtl/vr_pkg.sv | 11 +
 rtl/sat_counter.sv | 20 ++
 rtl/seq_check_consumer.sv | 125 ++++++++++++
 tb/tb_seq_check_consumer.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vr_pkg.sv
// Shared types and widths for the valid/rdy counting-stream demo chain.
package vr_pkg;

    localparam int unsigned VR_W = 8;

    typedef enum logic [0:0] {
        C_RDY  = 1'b0,
        C_HOLD = 1'b1
    } cons_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count increments, holding at the maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/seq_check_consumer.sv
// Stream sink: throttles the producer with a fixed hold pattern after each
// accepted word and checks that accepted words form a +1 sequence.
module seq_check_consumer
    import vr_pkg::*;
#(
    parameter int unsigned   W           = VR_W,
    parameter int unsigned   HOLD_CYCLES = 3,
    parameter logic [W-1:0]  START_VAL   = W'(1),
    parameter int unsigned   CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_rdy,
    input  logic             stall_en,
    output logic [W-1:0]     last_data,
    output logic             acc_pulse,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [7:0]       err_cnt
);

    localparam int unsigned HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned HOLD_LOAD = (HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0;

    cons_state_t     state;
    cons_state_t     state_nxt;
    logic [HC_W-1:0] hold_cnt;
    logic [HC_W-1:0] hold_cnt_nxt;
    logic [W-1:0]    exp_val;
    logic            xfer;
    logic            mismatch;

    assign xfer     = in_valid && in_rdy;
    assign mismatch = xfer && (in_data != exp_val);

    // State and hold counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= C_RDY;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Next state: hold off for HOLD_CYCLES after each accepted word.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            C_RDY: begin
                if (xfer && (HOLD_CYCLES > 0)) begin
                    state_nxt    = C_HOLD;
                    hold_cnt_nxt = HC_W'(HOLD_LOAD);
                end
            end
            C_HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = C_RDY;
                end else begin
                    hold_cnt_nxt = hold_cnt - HC_W'(1);
                end
            end
            default: begin
                state_nxt    = C_RDY;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    // Ready depends only on state and the stall hook, never on in_valid.
    always_comb begin
        in_rdy = 1'b0;
        if ((state == C_RDY) && !stall_en) begin
            in_rdy = 1'b1;
        end
    end

    // Capture, sequence check and resync of the expected value.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_data  <= '0;
            acc_pulse  <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            exp_val    <= START_VAL;
        end else begin
            acc_pulse <= xfer;
            err_pulse <= mismatch;
            if (mismatch) begin
                err_sticky <= 1'b1;
            end
            if (xfer) begin
                last_data <= in_data;
                exp_val   <= W'(in_data + W'(1));
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_xfer_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (xfer),
        .count (xfer_cnt)
    );

    sat_counter #(.WIDTH(8)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mismatch),
        .count (err_cnt)
    );

`ifndef SYNTHESIS
    // Upstream must hold its word while it is being back-pressured.
    a_data_stable: assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_rdy) |=> $stable(in_data))
        else $warning("in_data changed while stalled");
`endif

endmodule

// File: tb/tb_seq_check_consumer.sv
// Randomised and directed bench for seq_check_consumer with a reference model.
module tb_seq_check_consumer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: default parameters (hold 3, start 1).
    logic        rst_a = 1'b1, valid_a = 1'b0, stall_a = 1'b0;
    logic [7:0]  data_a = 8'h00;
    logic        rdy_a, acc_a, errp_a, stk_a;
    logic [7:0]  last_a, ecnt_a;
    logic [15:0] xcnt_a;

    seq_check_consumer u_a (
        .clk(clk), .rst(rst_a), .in_valid(valid_a), .in_data(data_a), .in_rdy(rdy_a),
        .stall_en(stall_a), .last_data(last_a), .acc_pulse(acc_a), .err_pulse(errp_a),
        .err_sticky(stk_a), .xfer_cnt(xcnt_a), .err_cnt(ecnt_a)
    );

    // Instance B: start value near the wrap point.
    logic        rst_b = 1'b1, valid_b = 1'b0, stall_b = 1'b0;
    logic [7:0]  data_b = 8'h00;
    logic        rdy_b, acc_b, errp_b, stk_b;
    logic [7:0]  last_b, ecnt_b;
    logic [15:0] xcnt_b;

    seq_check_consumer #(.START_VAL(8'hFD)) u_b (
        .clk(clk), .rst(rst_b), .in_valid(valid_b), .in_data(data_b), .in_rdy(rdy_b),
        .stall_en(stall_b), .last_data(last_b), .acc_pulse(acc_b), .err_pulse(errp_b),
        .err_sticky(stk_b), .xfer_cnt(xcnt_b), .err_cnt(ecnt_b)
    );

    // Instance S: back-to-back with a narrow transfer counter.
    logic        rst_s = 1'b1, valid_s = 1'b0, stall_s = 1'b0;
    logic [7:0]  data_s = 8'h00;
    logic        rdy_s, acc_s, errp_s, stk_s;
    logic [7:0]  last_s, ecnt_s;
    logic [3:0]  xcnt_s;

    seq_check_consumer #(.HOLD_CYCLES(0), .CNT_W(4)) u_s (
        .clk(clk), .rst(rst_s), .in_valid(valid_s), .in_data(data_s), .in_rdy(rdy_s),
        .stall_en(stall_s), .last_data(last_s), .acc_pulse(acc_s), .err_pulse(errp_s),
        .err_sticky(stk_s), .xfer_cnt(xcnt_s), .err_cnt(ecnt_s)
    );

    // Reference model for instance A: ready once 3 cycles have elapsed since
    // the last accepted word; counters and expected value from plain arithmetic.
    localparam int M_HOLD = 3;
    int         m_gap;
    logic [7:0] m_exp, m_last;
    int         m_xfer, m_err;
    logic       m_stk, m_acc, m_errp, m_xf_last;

    function automatic logic m_rdy();
        return (m_gap >= M_HOLD) && !stall_a;
    endfunction

    task automatic step_main();
        logic xf, mis;
        xf  = valid_a && m_rdy();
        mis = xf && (data_a != m_exp);
        @(posedge clk);
        #1;
        if (rst_a) begin
            m_gap = M_HOLD; m_exp = 8'h01; m_last = 8'h00; m_xfer = 0; m_err = 0;
            m_stk = 1'b0; m_acc = 1'b0; m_errp = 1'b0; m_xf_last = 1'b0;
        end else begin
            m_acc = xf; m_errp = mis; m_xf_last = xf;
            if (xf) begin
                m_last = data_a;
                m_exp  = data_a + 8'd1;
                if (m_xfer < 65535) m_xfer++;
                if (mis) begin
                    m_stk = 1'b1;
                    if (m_err < 255) m_err++;
                end
                m_gap = 0;
            end else if (m_gap < M_HOLD) begin
                m_gap++;
            end
        end
    endtask

    task automatic reset_main();
        rst_a = 1'b1; valid_a = 1'b0; stall_a = 1'b0;
        step_main();
        rst_a = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_main();
        for (int i = 0; i < 10; i++) begin
            total++;
            if (rdy_a !== 1'b1 || xcnt_a !== 16'd0 || ecnt_a !== 8'd0 || stk_a !== 1'b0 ||
                acc_a !== 1'b0 || errp_a !== 1'b0 || last_a !== 8'd0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d: rdy=%b xcnt=%0d ecnt=%0d stk=%b acc=%b errp=%b last=%0h, want 1 0 0 0 0 0 0",
                         i, rdy_a, xcnt_a, ecnt_a, stk_a, acc_a, errp_a, last_a);
            end
            step_main();
        end
    endtask

    task automatic test_stream();
        int w, cyc, prev_acc, ngap;
        reset_main();
        w = 1; cyc = 0; prev_acc = -1; ngap = 0;
        valid_a = 1'b1;
        while (w <= 20 && cyc < 200) begin
            data_a = 8'(w);
            step_main();
            cyc++;
            if (acc_a === 1'b1) begin
                if (prev_acc >= 0) begin
                    total++;
                    if (cyc - prev_acc != 4) begin
                        bad++;
                        $display("FAIL stream_spacing: got %0d cycles want 4", cyc - prev_acc);
                    end
                    ngap++;
                end
                prev_acc = cyc;
            end
            if (m_xf_last) w++;
        end
        valid_a = 1'b0;
        step_main();
        total++;
        if (cyc >= 200) begin
            bad++;
            $display("FAIL stream_timeout: accepted %0d of 20 words", w - 1);
        end
        total++;
        if (xcnt_a !== 16'd20 || ecnt_a !== 8'd0 || last_a !== 8'd20 || stk_a !== 1'b0) begin
            bad++;
            $display("FAIL stream_final: xcnt=%0d ecnt=%0d last=%0d stk=%b want 20 0 20 0",
                     xcnt_a, ecnt_a, last_a, stk_a);
        end
        total++;
        if (ngap != 19) begin
            bad++;
            $display("FAIL stream_pulses: got %0d gaps want 19", ngap);
        end
    endtask

    task automatic test_mismatch();
        logic [7:0] words [5];
        int i, cyc, npulse;
        logic [7:0] pulse_word;
        words = '{8'd1, 8'd2, 8'd7, 8'd8, 8'd9};
        reset_main();
        i = 0; cyc = 0; npulse = 0; pulse_word = 8'h00;
        while (i < 5 && cyc < 100) begin
            valid_a = 1'b1;
            data_a  = words[i];
            step_main();
            cyc++;
            if (errp_a === 1'b1) begin
                npulse++;
                pulse_word = last_a;
            end
            if (m_xf_last) i++;
        end
        valid_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step_main();
            if (errp_a === 1'b1) npulse++;
        end
        total++;
        if (npulse != 1 || pulse_word !== 8'd7) begin
            bad++;
            $display("FAIL mismatch_pulse: pulses=%0d word=%0d want 1 on word 7", npulse, pulse_word);
        end
        total++;
        if (ecnt_a !== 8'd1 || stk_a !== 1'b1 || xcnt_a !== 16'd5) begin
            bad++;
            $display("FAIL mismatch_counts: ecnt=%0d stk=%b xcnt=%0d want 1 1 5", ecnt_a, stk_a, xcnt_a);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] w;
        int n, cyc;
        logic xf;
        rst_b = 1'b1; tick(); rst_b = 1'b0;
        w = 8'hFD; n = 0; cyc = 0;
        valid_b = 1'b1;
        while (n < 6 && cyc < 100) begin
            data_b = w;
            #1;
            xf = rdy_b;
            tick();
            cyc++;
            if (xf) begin
                n++;
                w = w + 8'd1;
            end
        end
        valid_b = 1'b0;
        tick();
        total++;
        if (cyc >= 100) begin
            bad++;
            $display("FAIL wrap_timeout: accepted %0d of 6", n);
        end
        total++;
        if (ecnt_b !== 8'd0 || xcnt_b !== 16'd6 || last_b !== 8'h02 || stk_b !== 1'b0) begin
            bad++;
            $display("FAIL wrap_final: ecnt=%0d xcnt=%0d last=%0h stk=%b want 0 6 02 0",
                     ecnt_b, xcnt_b, last_b, stk_b);
        end
    endtask

    task automatic test_stall();
        reset_main();
        stall_a = 1'b1; valid_a = 1'b1; data_a = 8'd1;
        for (int i = 0; i < 12; i++) begin
            #1;
            total++;
            if (rdy_a !== 1'b0) begin
                bad++;
                $display("FAIL stall_rdy cyc=%0d: got %b want 0", i, rdy_a);
            end
            step_main();
            total++;
            if (acc_a !== 1'b0 || xcnt_a !== 16'd0) begin
                bad++;
                $display("FAIL stall_noxfer cyc=%0d: acc=%b xcnt=%0d want 0 0", i, acc_a, xcnt_a);
            end
        end
        stall_a = 1'b0;
        #1;
        total++;
        if (rdy_a !== 1'b1) begin
            bad++;
            $display("FAIL stall_release_rdy: got %b want 1", rdy_a);
        end
        step_main();
        valid_a = 1'b0;
        total++;
        if (acc_a !== 1'b1 || last_a !== 8'd1 || xcnt_a !== 16'd1 || ecnt_a !== 8'd0) begin
            bad++;
            $display("FAIL stall_release: acc=%b last=%0d xcnt=%0d ecnt=%0d want 1 1 1 0",
                     acc_a, last_a, xcnt_a, ecnt_a);
        end
    endtask

    task automatic test_rst_hold();
        reset_main();
        valid_a = 1'b1; data_a = 8'd1;
        step_main();
        valid_a = 1'b0; data_a = 8'd5;
        step_main();
        #1;
        total++;
        if (rdy_a !== 1'b0 || xcnt_a !== 16'd1) begin
            bad++;
            $display("FAIL rst_hold_pre: rdy=%b xcnt=%0d want 0 1", rdy_a, xcnt_a);
        end
        rst_a = 1'b1;
        step_main();
        rst_a = 1'b0;
        total++;
        if (rdy_a !== 1'b1 || xcnt_a !== 16'd0 || ecnt_a !== 8'd0 || last_a !== 8'd0 ||
            acc_a !== 1'b0 || stk_a !== 1'b0) begin
            bad++;
            $display("FAIL rst_hold_post: rdy=%b xcnt=%0d ecnt=%0d last=%0d acc=%b stk=%b want 1 0 0 0 0 0",
                     rdy_a, xcnt_a, ecnt_a, last_a, acc_a, stk_a);
        end
        valid_a = 1'b1; data_a = 8'd1;
        step_main();
        valid_a = 1'b0;
        total++;
        if (acc_a !== 1'b1 || errp_a !== 1'b0 || xcnt_a !== 16'd1 || ecnt_a !== 8'd0 || last_a !== 8'd1) begin
            bad++;
            $display("FAIL rst_hold_first: acc=%b errp=%b xcnt=%0d ecnt=%0d last=%0d want 1 0 1 0 1",
                     acc_a, errp_a, xcnt_a, ecnt_a, last_a);
        end
    endtask

    task automatic test_random();
        logic [7:0] next_seq;
        logic       xf;
        reset_main();
        next_seq = 8'd1;
        for (int c = 0; c < 400; c++) begin
            if (!valid_a && $urandom_range(0, 2) != 0) begin
                valid_a = 1'b1;
                data_a  = ($urandom_range(0, 5) == 0) ? 8'($urandom) : next_seq;
            end
            stall_a = ($urandom_range(0, 7) == 0);
            #1;
            total++;
            if (rdy_a !== m_rdy()) begin
                bad++;
                $display("FAIL random_rdy cyc=%0d: got %b want %b", c, rdy_a, m_rdy());
            end
            xf = valid_a && m_rdy();
            step_main();
            total++;
            if (acc_a !== m_acc || errp_a !== m_errp || last_a !== m_last ||
                xcnt_a !== 16'(m_xfer) || ecnt_a !== 8'(m_err) || stk_a !== m_stk) begin
                bad++;
                $display("FAIL random_out cyc=%0d: acc=%b errp=%b last=%0h xcnt=%0d ecnt=%0d stk=%b want %b %b %0h %0d %0d %b",
                         c, acc_a, errp_a, last_a, xcnt_a, ecnt_a, stk_a,
                         m_acc, m_errp, m_last, m_xfer, m_err, m_stk);
            end
            if (xf) begin
                valid_a  = 1'b0;
                next_seq = data_a + 8'd1;
            end
        end
        valid_a = 1'b0; stall_a = 1'b0;
    endtask

    task automatic test_saturate();
        rst_s = 1'b1; tick(); rst_s = 1'b0;
        valid_s = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            data_s = 8'(k);
            #1;
            total++;
            if (rdy_s !== 1'b1) begin
                bad++;
                $display("FAIL b2b_rdy word=%0d: got %b want 1", k, rdy_s);
            end
            tick();
            total++;
            if (xcnt_s !== 4'((k > 15) ? 15 : k) || acc_s !== 1'b1) begin
                bad++;
                $display("FAIL xfer_sat word=%0d: xcnt=%0d acc=%b want %0d 1",
                         k, xcnt_s, acc_s, (k > 15) ? 15 : k);
            end
        end
        total++;
        if (ecnt_s !== 8'd0 || last_s !== 8'd20) begin
            bad++;
            $display("FAIL b2b_clean: ecnt=%0d last=%0d want 0 20", ecnt_s, last_s);
        end
        for (int k = 0; k < 300; k++) begin
            data_s = 8'h00;
            tick();
        end
        valid_s = 1'b0;
        tick();
        total++;
        if (ecnt_s !== 8'd255 || stk_s !== 1'b1 || xcnt_s !== 4'd15) begin
            bad++;
            $display("FAIL err_sat: ecnt=%0d stk=%b xcnt=%0d want 255 1 15", ecnt_s, stk_s, xcnt_s);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_mismatch();
        test_wrap();
        test_stall();
        test_rst_hold();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
